pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit; the producer of the `stall` and `flush` signals consumed by the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data-bus wait) into a 6-bit per-stage stall vector.
- On an exception committed in MEM, generates a flush sequence and the redirect PC (handler vector, or EPC for ERET).
- Keeps a saturating stall-cycle counter and a sticky stall-timeout flag for debug.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler address for every exception except ERET.
- FLUSH_CYCLES, 1, cycles `flush` stays asserted per exception (1..4).
- MAX_STALL, 255, consecutive stalled cycles before `stall_timeout` sets.
- CNT_W, 16, width of `stall_cycles`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- stallreq_id  in  1  load-use hazard from ID.
- stallreq_ex  in  1  multi-cycle EX op busy.
- stallreq_mem  in  1  data memory not ready.
- mem_excepttype  in  32  exception type from MEM stage; 0 = none.
- cp0_epc  in  32  current EPC from CP0, with the MEM-stage MTC0 already forwarded.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- flush  out  1  flush all pipeline registers.
- new_pc  out  32  redirect target; valid while `flush` = 1.
- stall_cycles  out  CNT_W  saturating count of cycles with stall != 0.
- stall_timeout  out  1  sticky; set when a stall run reaches MAX_STALL.

Behaviour:
- FSM states: RUN, FLUSH. Reset (rst = 0 at a clock edge) puts the FSM in RUN and clears stall_cycles, stall_timeout, the run counter and the held PC.
- While rst = 0, all outputs read 0. This is decoded combinationally from rst.
- Stall vector (combinational, RUN only, no exception this cycle). First match wins:
  - stallreq_mem: 6'b011111
  - stallreq_ex: 6'b001111
  - stallreq_id: 6'b000111
  - otherwise: 6'b000000
- Stage 3 not stalled while stage 2 is stalled is how the downstream register inserts a bubble.
- Exception detect: in RUN with mem_excepttype != 0, in the same cycle:
  - flush = 1 and stall = 0. Exception beats every stall request.
  - new_pc = cp0_epc if mem_excepttype == 32'h0000_000e (ERET), otherwise EXC_VECTOR.
  - new_pc is registered into the held PC.
  - If FLUSH_CYCLES > 1, go to FLUSH with flush counter = FLUSH_CYCLES-1; otherwise stay in RUN.
- FLUSH state:
  - flush = 1, stall = 0, new_pc = held PC.
  - mem_excepttype and stall requests are ignored.
  - Counter decrements; return to RUN when it reaches 1 at the clock edge.
- Latency: flush and new_pc are combinational, asserted in the same cycle as the exception input. Pipeline registers act on the next edge.
- Stall run counter:
  - Increments each cycle stall != 0; clears on any cycle stall == 0 or flush == 1.
  - When it equals MAX_STALL-1 and stall != 0, set stall_timeout. It then holds until reset.
  - Saturates at MAX_STALL.
- stall_cycles increments each cycle stall != 0 and saturates at all-ones (no wrap).
- An exception arriving in the same cycle as all three stall requests: flush = 1, stall = 0, and stall_cycles does not increment.
- Reset asserted during FLUSH: return to RUN and deassert flush; no redirect is pending afterwards.

Decomposition:
- Shared defines header:
  - `Stall`/`NoStall` and `FLUSH` encodings.
  - Stall-vector constants STALL_NONE/STALL_ID/STALL_EX/STALL_MEM.
  - Exception type codes (INT 0x1, SYSCALL 0x8, INST_INVALID 0xa, TRAP 0xd, OV 0xc, ERET 0xe).
  - EXC_VECTOR default.
- One natural sub-module: sat_counter (parameterised width and limit, with clear and enable). Used for both stall_cycles and the run counter.

Test Plan:
- Idle: all requests 0, mem_excepttype = 0 for 10 cycles -> stall = 000000, flush = 0, stall_cycles = 0.
- Priority: stallreq_id = 1 and stallreq_ex = 1 together -> stall = 001111; then stallreq_mem = 1 as well -> stall = 011111; stall_cycles counts 2.
- SYSCALL: mem_excepttype = 32'h8 with stallreq_ex = 1 -> same cycle flush = 1, stall = 0, new_pc = 32'h20. FLUSH_CYCLES = 3 -> flush high for exactly 3 cycles; a second exception in cycle 2 is ignored.
- ERET: cp0_epc = 32'hBFC0_0100, mem_excepttype = 32'he -> flush = 1, new_pc = 32'hBFC0_0100. Change cp0_epc during FLUSH -> new_pc unchanged.
- Timeout: MAX_STALL = 4, stallreq_id held 4 cycles -> stall_timeout rises at the 4th stalled cycle edge and stays 1 after the request drops. stall_cycles saturates at 16'hFFFF under a long stall with CNT_W = 16.
- Reset mid-FLUSH: rst = 0 during FLUSH cycle 2 -> next cycle flush = 0, stall = 0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: stall/flush levels, stall vectors,
// exception type codes and the FSM state type.
package pipe_ctrl_pkg;

    localparam logic Stall   = 1'b1;
    localparam logic NoStall = 1'b0;
    localparam logic FLUSH   = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } pipe_state_e;

    // Deepest requesting stage wins; a later stage stall must freeze everything before it.
    function automatic logic [5:0] stall_vec(input logic req_mem, input logic req_ex,
                                             input logic req_id);
        if (req_mem == Stall) begin
            return STALL_MEM;
        end else if (req_ex == Stall) begin
            return STALL_EX;
        end else if (req_id == Stall) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear and enable; holds at Limit.
module sat_counter #(
    parameter int unsigned     Width = 8,
    parameter logic [Width-1:0] Limit = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates stage stall requests and sequences exception flushes
// with the redirect PC; keeps stall statistics for debug.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      mem_excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int unsigned RunW      = $clog2(MAX_STALL + 1);
    localparam logic [2:0]  FlushInit = 3'(FLUSH_CYCLES - 1);

    pipe_state_e     state_q;
    logic [2:0]      flush_cnt_q;
    logic [31:0]     held_pc_q;
    logic            timeout_q;

    logic            exc_taken;
    logic            flush_int;
    logic [5:0]      stall_int;
    logic [31:0]     pc_int;
    logic            stalling;
    logic [RunW-1:0] run_cnt;
    logic [CNT_W-1:0] total_cnt;

    always_comb begin
        exc_taken = (state_q == StRun) && (mem_excepttype != '0);
        stall_int = STALL_NONE;
        flush_int = 1'b0;
        pc_int    = '0;
        if (state_q == StFlush) begin
            flush_int = FLUSH;
            pc_int    = held_pc_q;
        end else if (exc_taken) begin
            flush_int = FLUSH;
            pc_int    = (mem_excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        end else begin
            stall_int = stall_vec(stallreq_mem, stallreq_ex, stallreq_id);
        end
    end

    assign stalling = (stall_int != STALL_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            held_pc_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (stalling && (run_cnt == RunW'(MAX_STALL - 1))) begin
                timeout_q <= 1'b1;
            end
            unique case (state_q)
                StRun: begin
                    if (exc_taken) begin
                        held_pc_q <= pc_int;
                        if (FLUSH_CYCLES > 1) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= FlushInit;
                        end
                    end
                end
                StFlush: begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_q <= StRun;
                    end
                    flush_cnt_q <= flush_cnt_q - 3'd1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Length of the current uninterrupted stall run, feeds the timeout detector.
    sat_counter #(
        .Width (RunW),
        .Limit (RunW'(MAX_STALL))
    ) u_run_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (!stalling || flush_int),
        .en_i    (stalling),
        .count_o (run_cnt)
    );

    sat_counter #(
        .Width (CNT_W),
        .Limit ({CNT_W{1'b1}})
    ) u_total_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (1'b0),
        .en_i    (stalling),
        .count_o (total_cnt)
    );

    // Everything reads zero while reset is held, independent of the clock.
    assign stall         = rst ? stall_int : '0;
    assign flush         = rst ? flush_int : 1'b0;
    assign new_pc        = rst ? pc_int    : '0;
    assign stall_cycles  = rst ? total_cnt : '0;
    assign stall_timeout = rst ? timeout_q : 1'b0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 3-cycle-flush/short-timeout instance and a
// default instance with a narrow stall counter, sharing the same stimulus.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] mem_excepttype, cp0_epc;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cycles;
    logic        stall_timeout;

    logic [5:0]  b_stall;
    logic        b_flush;
    logic [31:0] b_new_pc;
    logic [3:0]  b_stall_cycles;
    logic        b_stall_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .FLUSH_CYCLES (3),
        .MAX_STALL    (4),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .mem_excepttype (mem_excepttype),
        .cp0_epc        (cp0_epc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_cycles   (stall_cycles),
        .stall_timeout  (stall_timeout)
    );

    pipe_ctrl #(
        .CNT_W (4)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .mem_excepttype (mem_excepttype),
        .cp0_epc        (cp0_epc),
        .stall          (b_stall),
        .flush          (b_flush),
        .new_pc         (b_new_pc),
        .stall_cycles   (b_stall_cycles),
        .stall_timeout  (b_stall_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic ex, input logic mem);
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
    endtask

    initial begin
        rst            = 1'b0;
        cp0_epc        = 32'h0;
        mem_excepttype = 32'h8;
        set_req(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check_eq("rst_stall", 32'(stall), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_new_pc", new_pc, 32'h0);
        check_eq("rst_cycles", 32'(stall_cycles), 32'h0);
        check_eq("rst_timeout", 32'(stall_timeout), 32'h0);

        mem_excepttype = 32'h0;
        set_req(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_stall", 32'(stall), 32'h0);
            check_eq("idle_flush", 32'(flush), 32'h0);
            tick();
        end
        check_eq("idle_cycles", 32'(stall_cycles), 32'd0);

        set_req(1'b1, 1'b1, 1'b0);
        #1 check_eq("prio_id_ex", 32'(stall), 32'h0f);
        tick();
        set_req(1'b1, 1'b1, 1'b1);
        #1 check_eq("prio_all", 32'(stall), 32'h1f);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        #1 check_eq("prio_release", 32'(stall), 32'h0);
        check_eq("prio_cycles", 32'(stall_cycles), 32'd2);
        check_eq("prio_no_timeout", 32'(stall_timeout), 32'h0);
        tick();

        // SYSCALL with every stall request raised; second exception lands mid-flush.
        set_req(1'b1, 1'b1, 1'b1);
        mem_excepttype = 32'h8;
        #1 check_eq("sys_c1_flush", 32'(flush), 32'h1);
        check_eq("sys_c1_stall", 32'(stall), 32'h0);
        check_eq("sys_c1_pc", new_pc, 32'h20);
        check_eq("b_sys_flush", 32'(b_flush), 32'h1);
        tick();
        check_eq("sys_no_count", 32'(stall_cycles), 32'd2);
        mem_excepttype = 32'he;
        cp0_epc        = 32'h0000_1234;
        #1 check_eq("sys_c2_flush", 32'(flush), 32'h1);
        check_eq("sys_c2_stall", 32'(stall), 32'h0);
        check_eq("sys_c2_pc", new_pc, 32'h20);
        tick();
        mem_excepttype = 32'h0;
        #1 check_eq("sys_c3_flush", 32'(flush), 32'h1);
        check_eq("sys_c3_stall", 32'(stall), 32'h0);
        check_eq("sys_c3_pc", new_pc, 32'h20);
        tick();
        set_req(1'b0, 1'b0, 1'b0);
        #1 check_eq("sys_c4_flush", 32'(flush), 32'h0);
        check_eq("sys_cycles", 32'(stall_cycles), 32'd2);
        tick();

        cp0_epc        = 32'hBFC0_0100;
        mem_excepttype = 32'he;
        #1 check_eq("eret_c1_flush", 32'(flush), 32'h1);
        check_eq("eret_c1_pc", new_pc, 32'hBFC0_0100);
        tick();
        mem_excepttype = 32'h0;
        cp0_epc        = 32'hDEAD_0000;
        #1 check_eq("eret_c2_flush", 32'(flush), 32'h1);
        check_eq("eret_c2_pc", new_pc, 32'hBFC0_0100);
        check_eq("b_eret_c2_flush", 32'(b_flush), 32'h0);
        tick();
        check_eq("eret_c3_flush", 32'(flush), 32'h1);
        check_eq("eret_c3_pc", new_pc, 32'hBFC0_0100);
        tick();
        check_eq("eret_c4_flush", 32'(flush), 32'h0);

        set_req(1'b1, 1'b0, 1'b0);
        #1 check_eq("to_stall", 32'(stall), 32'h07);
        tick();
        tick();
        tick();
        check_eq("to_before", 32'(stall_timeout), 32'h0);
        tick();
        check_eq("to_set", 32'(stall_timeout), 32'h1);
        set_req(1'b0, 1'b0, 1'b0);
        tick();
        check_eq("to_sticky", 32'(stall_timeout), 32'h1);
        check_eq("to_cycles", 32'(stall_cycles), 32'd6);

        set_req(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        set_req(1'b0, 1'b0, 1'b0);
        check_eq("sat_b_cycles", 32'(b_stall_cycles), 32'hf);
        check_eq("sat_b_timeout", 32'(b_stall_timeout), 32'h0);
        check_eq("sat_cycles", 32'(stall_cycles), 32'd26);
        tick();

        mem_excepttype = 32'h8;
        tick();
        mem_excepttype = 32'h0;
        rst            = 1'b0;
        #1 check_eq("rstfl_flush_now", 32'(flush), 32'h0);
        tick();
        rst = 1'b1;
        #1 check_eq("rstfl_flush", 32'(flush), 32'h0);
        check_eq("rstfl_stall", 32'(stall), 32'h0);
        check_eq("rstfl_cycles", 32'(stall_cycles), 32'h0);
        check_eq("rstfl_timeout", 32'(stall_timeout), 32'h0);
        tick();
        check_eq("rstfl_no_pending", 32'(flush), 32'h0);
        set_req(1'b1, 1'b0, 1'b0);
        #1 check_eq("rstfl_run", 32'(stall), 32'h07);
        tick();
        set_req(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
